// File: rtl/mandelbrot_pixel_sink.sv
// Consumer side of the Mandelbrot engine run/running handshake: issues one run per pixel,
// packs two 4-bit iteration counts per byte into a small FIFO and streams them out with sof/last.
module mandelbrot_pixel_sink #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       enable,
   output logic       eng_run,
   input  logic       eng_running,
   input  logic [3:0] eng_ctr,
   input  logic       eng_finished,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sof,
   output logic       out_last,
   output logic       busy,
   output logic       frame_done,
   output logic       error
);

   localparam int unsigned TOTAL = WIDTH * HEIGHT;
   localparam int unsigned PW    = $clog2(TOTAL + 1);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_PACK, S_DRAIN
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_pixel;
   logic            r_holding;
   logic [3:0]      r_held;
   logic [3:0]      r_cap_ctr;
   logic            r_cap_fin;
   logic            r_sof_pending;
   logic            r_eng_run;
   logic            r_busy;
   logic            r_frame_done;
   logic            r_error;

   // FIFO entry layout: {last, sof, data[7:0]}
   logic [9:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_valid;

   logic            w_last_pix;
   logic            w_push;
   logic            w_pop;
   logic [7:0]      w_push_data;
   logic [CW-1:0]   w_count_nxt;

   assign w_last_pix  = (r_pixel == PW'(TOTAL));
   // A held nibble always pairs with the new one; an unpaired final pixel pads the high nibble.
   assign w_push      = (r_state == S_PACK) && (r_holding || w_last_pix);
   assign w_push_data = r_holding ? {r_cap_ctr, r_held} : {4'h0, r_cap_ctr};
   assign w_pop       = r_valid && out_ready;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   assign eng_run    = r_eng_run;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign error      = r_error;
   assign out_valid  = r_valid;
   assign {out_last, out_sof, out_data} = r_mem[r_rd_ptr];

   // Pixel sequencing state machine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pixel       <= '0;
         r_holding     <= 1'b0;
         r_held        <= '0;
         r_cap_ctr     <= '0;
         r_cap_fin     <= 1'b0;
         r_sof_pending <= 1'b0;
         r_eng_run     <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_eng_run    <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!eng_finished) begin
                     r_error <= 1'b1;
                  end else begin
                     r_pixel       <= '0;
                     r_holding     <= 1'b0;
                     r_sof_pending <= 1'b1;
                     r_busy        <= 1'b1;
                     r_state       <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (enable && (r_count < CW'(DEPTH))) begin
                  r_eng_run <= 1'b1;
                  r_state   <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (eng_running) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (!eng_running) begin
                  r_cap_ctr <= eng_ctr;
                  r_cap_fin <= eng_finished;
                  r_pixel   <= r_pixel + PW'(1);
                  r_state   <= S_PACK;
               end
            end
            S_PACK: begin
               if (w_push) begin
                  r_holding     <= 1'b0;
                  r_sof_pending <= 1'b0;
               end else begin
                  r_held    <= r_cap_ctr;
                  r_holding <= 1'b1;
               end
               // Engine's finished flag must coincide exactly with the final pixel
               if (r_cap_fin != w_last_pix) r_error <= 1'b1;
               r_state <= w_last_pix ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: begin
               if (w_count_nxt == '0) begin
                  r_frame_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Byte FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(DEPTH); k++) r_mem[k] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_pix, r_sof_pending, w_push_data};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
      end
   end

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Bench for mandelbrot_pixel_sink: two instances (4x2 with a 2-deep FIFO, 3x1 with a 4-deep FIFO)
// driven by a behavioural engine, checked against hand-written vectors and a pixel-pairing model.
module tb_mandelbrot_pixel_sink;

   typedef struct packed { logic [7:0] d; logic s; logic l; } rec_t;
   typedef struct { int inst; logic [3:0] v [8]; logic [7:0] e [4]; int ne; } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start [2];
   logic       enable [2];
   logic       run [2];
   logic       running [2];
   logic [3:0] ctr [2];
   logic       fin_r [2];
   logic       fin_kill [2];
   logic       fin [2];
   logic [7:0] odata [2];
   logic       ovalid [2];
   logic       oready [2];
   logic       osof [2];
   logic       olast [2];
   logic       busy [2];
   logic       fdone [2];
   logic       err [2];

   logic [3:0] vals [2][8];
   int         total [2] = '{8, 3};
   int         force_pix [2];
   bit         rnd_lat;
   int         ecnt [2];
   int         pix [2];

   rec_t       got [2][64];
   int         ngot [2], nrun [2], nfd [2], fdcyc [2], lastpop [2], viol [2];
   logic       pstall [2];
   logic [7:0] pd [2];
   int         cyc;

   int         n_checks, n_fail;
   vec_t       tv [4];

   always #5 clk = ~clk;

   assign fin[0] = fin_r[0] & ~fin_kill[0];
   assign fin[1] = fin_r[1] & ~fin_kill[1];

   mandelbrot_pixel_sink #(.WIDTH(4), .HEIGHT(2), .DEPTH(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .enable(enable[0]),
      .eng_run(run[0]), .eng_running(running[0]), .eng_ctr(ctr[0]), .eng_finished(fin[0]),
      .out_data(odata[0]), .out_valid(ovalid[0]), .out_ready(oready[0]),
      .out_sof(osof[0]), .out_last(olast[0]), .busy(busy[0]),
      .frame_done(fdone[0]), .error(err[0]));

   mandelbrot_pixel_sink #(.WIDTH(3), .HEIGHT(1), .DEPTH(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .enable(enable[1]),
      .eng_run(run[1]), .eng_running(running[1]), .eng_ctr(ctr[1]), .eng_finished(fin[1]),
      .out_data(odata[1]), .out_valid(ovalid[1]), .out_ready(oready[1]),
      .out_sof(osof[1]), .out_last(olast[1]), .busy(busy[1]),
      .frame_done(fdone[1]), .error(err[1]));

   // Behavioural engine: running rises the cycle after run, stays high for the compute time
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            running[i] <= 1'b0; fin_r[i] <= 1'b1; ctr[i] <= 4'h0; pix[i] <= 0; ecnt[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!running[i] && run[i]) begin
               running[i] <= 1'b1;
               fin_r[i]   <= 1'b0;
               ecnt[i]    <= rnd_lat ? int'($urandom_range(1, 4)) : 3;
            end else if (running[i]) begin
               if (ecnt[i] <= 1) begin
                  running[i] <= 1'b0;
                  ctr[i]     <= vals[i][pix[i][2:0]];
                  fin_r[i]   <= (pix[i] + 1 == total[i]) || (pix[i] + 1 == force_pix[i]);
                  pix[i]     <= (pix[i] + 1 == total[i]) ? 0 : pix[i] + 1;
               end
               ecnt[i] <= ecnt[i] - 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: records accepted bytes, run pulses, frame_done and stall stability
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ovalid[i] && oready[i]) begin
            got[i][ngot[i][5:0]] <= '{d: odata[i], s: osof[i], l: olast[i]};
            ngot[i] <= ngot[i] + 1;
            if (olast[i]) lastpop[i] <= cyc;
         end
         if (run[i]) nrun[i] <= nrun[i] + 1;
         if (fdone[i]) begin nfd[i] <= nfd[i] + 1; fdcyc[i] <= cyc; end
         if (!rst_n) pstall[i] <= 1'b0;
         else begin
            if (pstall[i] && (!ovalid[i] || odata[i] != pd[i])) viol[i] <= viol[i] + 1;
            pstall[i] <= ovalid[i] && !oready[i];
            pd[i]     <= odata[i];
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input int i, input string tag);
      chk({tag, "_busy"}, int'(busy[i]), 0);
      chk({tag, "_valid"}, int'(ovalid[i]), 0);
      chk({tag, "_data"}, int'(odata[i]), 0);
      chk({tag, "_sof_last"}, int'({osof[i], olast[i]}), 0);
      chk({tag, "_run"}, int'(run[i]), 0);
      chk({tag, "_done_err"}, int'({fdone[i], err[i]}), 0);
   endtask

   task automatic pulse_start(input int i);
      @(posedge clk); #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
   endtask

   task automatic wait_frame(input int i, input int fd0, input bit rnd);
      int n = 0;
      while (nfd[i] == fd0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (rnd) begin
            oready[i] = ($urandom_range(0, 3) != 0);
            enable[i] = ($urandom_range(0, 7) != 0);
         end
      end
      oready[i] = 1'b1;
      enable[i] = 1'b1;
      chk($sformatf("frame_timeout%0d", i), int'(nfd[i] != fd0), 1);
   endtask

   task automatic check_frame(input int i, input int gb, input int rb,
                              input logic [7:0] e [4], input int ne, input string tag);
      rec_t r;
      chk({tag, "_nbytes"}, ngot[i] - gb, ne);
      chk({tag, "_nrun"}, nrun[i] - rb, total[i]);
      for (int j = 0; j < ne && j < ngot[i] - gb; j++) begin
         r = got[i][(gb + j) % 64];
         chk($sformatf("%s_data%0d", tag, j), int'(r.d), int'(e[j]));
         chk($sformatf("%s_sof%0d", tag, j), int'(r.s), int'(j == 0));
         chk($sformatf("%s_last%0d", tag, j), int'(r.l), int'(j == ne - 1));
      end
   endtask

   task automatic frame(input int i, input logic [7:0] e [4], input int ne,
                        input bit rnd, input string tag);
      int gb = ngot[i], rb = nrun[i], fd0 = nfd[i];
      pulse_start(i);
      wait_frame(i, fd0, rnd);
      check_frame(i, gb, rb, e, ne, tag);
   endtask

   initial begin
      logic [7:0] e [4];
      int gb, rb, fd0, n, i, ne;
      n_checks = 0; n_fail = 0; rnd_lat = 1'b0; cyc = 0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 0; enable[k] = 1; oready[k] = 1; fin_kill[k] = 0; force_pix[k] = 0;
         ngot[k] = 0; nrun[k] = 0; nfd[k] = 0; viol[k] = 0; fdcyc[k] = 0; lastpop[k] = 0;
      end
      tv[0] = '{inst: 0, v: '{1, 2, 3, 4, 5, 6, 7, 8}, e: '{8'h21, 8'h43, 8'h65, 8'h87}, ne: 4};
      tv[1] = '{inst: 1, v: '{5, 6, 7, 0, 0, 0, 0, 0}, e: '{8'h65, 8'h07, 0, 0}, ne: 2};
      tv[2] = '{inst: 0, v: '{4'hF, 4'h0, 4'hA, 4'h5, 4'h3, 4'hC, 4'h9, 4'hE},
                e: '{8'h0F, 8'h5A, 8'hC3, 8'hE9}, ne: 4};
      tv[3] = '{inst: 1, v: '{4'h0, 4'hF, 4'h1, 0, 0, 0, 0, 0}, e: '{8'hF0, 8'h01, 0, 0}, ne: 2};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk_idle(0, "rst_a");
      chk_idle(1, "rst_b");

      // Directed vectors
      for (int k = 0; k < 4; k++) begin
         i = tv[k].inst;
         vals[i] = tv[k].v;
         frame(i, tv[k].e, tv[k].ne, 1'b0, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d_err", k), int'(err[i]), 0);
         chk($sformatf("vec%0d_done_lat", k), fdcyc[i] - lastpop[i], 1);
         chk($sformatf("vec%0d_busy", k), int'(busy[i]), 0);
      end

      // Back-pressure: 2-deep FIFO fills after four pixels and issue stalls
      vals[0] = tv[0].v;
      gb = ngot[0]; rb = nrun[0]; fd0 = nfd[0];
      oready[0] = 1'b0;
      pulse_start(0);
      repeat (60) @(posedge clk);
      #1 chk("bp_nrun", nrun[0] - rb, 4);
      chk("bp_valid", int'(ovalid[0]), 1);
      chk("bp_head", int'(odata[0]), 8'h21);
      chk("bp_sof", int'(osof[0]), 1);
      chk("bp_nbytes", ngot[0] - gb, 0);
      oready[0] = 1'b1;
      wait_frame(0, fd0, 1'b0);
      check_frame(0, gb, rb, tv[0].e, 4, "bp");

      // Pause while pixel 3 is in flight; a stray start is ignored
      gb = ngot[0]; rb = nrun[0]; fd0 = nfd[0];
      pulse_start(0);
      n = 0;
      while (!(nrun[0] - rb == 3 && running[0]) && n < 200) begin @(posedge clk); #1 n++; end
      chk("pause_reach", int'(n < 200), 1);
      @(posedge clk); #1 enable[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("pause_nrun", nrun[0] - rb, 3);
      chk("pause_nbytes", ngot[0] - gb, 1);
      chk("pause_busy", int'(busy[0]), 1);
      pulse_start(0);
      enable[0] = 1'b1;
      wait_frame(0, fd0, 1'b0);
      check_frame(0, gb, rb, tv[0].e, 4, "pause");
      chk("pause_frames", nfd[0] - fd0, 1);

      // Randomized frames against the pairing model
      rnd_lat = 1'b1;
      for (int r = 0; r < 8; r++) begin
         i = int'($urandom_range(0, 1));
         for (int p = 0; p < 8; p++) vals[i][p] = 4'($urandom);
         ne = (total[i] + 1) / 2;
         for (int j = 0; j < 4; j++)
            e[j] = (j >= ne) ? 8'h00 :
                   {(2 * j + 1 < total[i]) ? vals[i][2 * j + 1] : 4'h0, vals[i][2 * j]};
         frame(i, e, ne, 1'b1, $sformatf("rnd%0d", r));
      end
      rnd_lat = 1'b0;
      chk("rnd_err", int'({err[0], err[1]}), 0);

      // Engine reports finished early: sticky error, frame still completes
      vals[0] = tv[0].v;
      force_pix[0] = 6;
      frame(0, tv[0].e, 4, 1'b0, "early");
      force_pix[0] = 0;
      chk("early_err", int'(err[0]), 1);
      fin_kill[0] = 1'b1;
      rb = nrun[0];
      pulse_start(0);
      repeat (10) @(posedge clk);
      #1 chk("nofin_err", int'(err[0]), 1);
      chk("nofin_busy", int'(busy[0]), 0);
      chk("nofin_nrun", nrun[0] - rb, 0);
      fin_kill[0] = 1'b0;

      // Asynchronous reset mid-frame, then a clean frame
      rb = nrun[0];
      pulse_start(0);
      n = 0;
      while (nrun[0] - rb < 3 && n < 200) begin @(posedge clk); #1 n++; end
      chk("mid_reach", int'(n < 200), 1);
      #2 rst_n = 1'b0;
      #1 chk_idle(0, "midrst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      frame(0, tv[0].e, 4, 1'b0, "postrst");
      chk("postrst_err", int'(err[0]), 0);

      chk("stall_stable", viol[0] + viol[1], 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mandelbrot_pixel_sink.md
Name: mandelbrot_pixel_sink

Overview:
- Consumer end of the Mandelbrot engine's per-pixel run/running handshake.
- Issues one `run` pulse per pixel and captures the 4-bit `ctr_out` when the engine stops.
- Packs two pixels per byte into a small FIFO and streams bytes out on a valid/ready interface, with start-of-frame and last markers.
- Back-pressure from the byte stream throttles the engine. The engine never runs ahead of buffer space.

Parameters:
- WIDTH, 320: pixels per line (must match engine).
- HEIGHT, 240: lines per frame (must match engine).
- DEPTH, 4: byte FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a frame when in IDLE
- enable  in  1  level; 0 = pause issuing new pixels
- eng_run  out  1  to engine `run`
- eng_running  in  1  from engine `running`
- eng_ctr  in  4  from engine `ctr_out`
- eng_finished  in  1  from engine `finished`
- out_data  out  8  packed pixels; bits [3:0] = earlier pixel
- out_valid  out  1  byte available
- out_ready  in  1  consumer accepts
- out_sof  out  1  qualifies the first byte of the frame
- out_last  out  1  qualifies the final byte of the frame
- busy  out  1  frame in progress
- frame_done  out  1  single-cycle pulse at end of frame
- error  out  1  sticky frame/pixel-count mismatch

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; pixel counter 0; nibble-holding flag 0.
- TOTAL = WIDTH*HEIGHT. The pixel counter is $clog2(TOTAL+1) bits.

State machine:
- IDLE:
  - On start=1: if eng_finished=0, set error, stay in IDLE.
  - Otherwise clear the pixel counter and holding flag, set sof_pending, go to ISSUE.
  - start is ignored outside IDLE.
- ISSUE:
  - When enable=1 and fifo_count<DEPTH, drive eng_run=1 for exactly this cycle, then go to WAIT_BUSY.
  - Otherwise hold with eng_run=0.
- WAIT_BUSY: wait for eng_running=1, then go to WAIT_DONE. eng_run stays 0.
- WAIT_DONE: wait for eng_running=0. In that same cycle, capture eng_ctr and eng_finished, increment the pixel counter, go to PACK.
- PACK (one cycle):
  - If holding=0: store the nibble, set holding=1.
  - If holding=1: push {new, held} to the FIFO, clear holding.
  - If this is pixel TOTAL (odd TOTAL): push {4'h0, new} instead.
  - Each pushed entry carries the sof tag (sof_pending, then clear it) and the last tag (pixel==TOTAL).
  - Next state: if pixel==TOTAL go to DRAIN, else go to ISSUE.
- DRAIN: wait until the FIFO is empty, pulse frame_done, go to IDLE.

Rules:
- Latency: eng_run is asserted the cycle after entering ISSUE with space available. The byte appears on out_valid one cycle after the PACK push.
- Space check: fifo_count<DEPTH is checked at issue time. Only one pixel is ever in flight, so a push can never overflow.
- Simultaneous push and pop: fifo_count is unchanged and both operations occur.
- busy = (state != IDLE).
- FIFO output:
  - out_valid = !empty.
  - out_data, out_sof and out_last come from the head entry.
  - A pop occurs when out_valid & out_ready.
  - Data is stable while valid & !ready.
- Pause: enable=0 lets the in-flight pixel complete and pack, then holds in ISSUE. Counters are preserved and the frame resumes on enable=1.
- Consistency check, at the PACK stage (sets error):
  - Captured finished=1 with pixel!=TOTAL → set error.
  - pixel==TOTAL with captured finished=0 → set error.
  - The frame still completes normally.
- error clears only on reset.
- Reset mid-frame: all state is cleared immediately and any in-flight data is discarded.

Test Plan:
- W=4,H=2, behavioural engine model (run→running next cycle, 3-cycle compute, ctr values 1..8), out_ready=1 → bytes 0x21,0x43,0x65,0x87; sof on byte 0, last on byte 3; frame_done one cycle after the last pop; exactly 8 eng_run pulses.
- W=3,H=1, ctr 5,6,7 → bytes 0x65, 0x07; last on 0x07; error=0.
- DEPTH=2, out_ready=0 throughout → after 4 pixels (2 bytes) eng_run stays 0. Raise out_ready → pixels resume; no bytes lost or duplicated.
- enable dropped during WAIT_DONE of pixel 3 → pixel 3 is packed, no further eng_run. enable=1 after 20 cycles → pixel 4 issued, output identical to the uninterrupted run.
- Model asserts finished on pixel 6 of 8 → error=1 (sticky), frame still ends with last on byte 3. A second start with eng_finished=0 → error stays 1, busy stays 0.
- rst_n pulsed low mid-frame → all outputs 0 asynchronously. A new start then produces a clean frame starting with sof.
